uart_reg_responder: RTL and testbench

//  - Command-frame responder on the device side of the UART byte link. Consumes received bytes
//    (rx_data/rx_ready) and drives transmit bytes (tx_en/tx_data/tx_done).
//  - Decodes read/write register frames, executes them on a simple register bus, returns a status frame.
//  - Sits between the uart byte interface and a register bank. Answers frames sent by the host.

---
 rtl/uart_reg_responder.sv | 158 +++++++++++++++
 tb/tb_uart_reg_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Command-frame responder on the UART byte link: decodes read/write register frames, drives the register bus, and answers with a status frame.
// Optional inter-byte timeout is enabled by defining UART_RESP_TIMEOUT_EN.
module uart_reg_responder #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata
);

  localparam logic [7:0] SYNC_REQ  = 8'hA5;
  localparam logic [7:0] SYNC_RESP = 8'h5A;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_SEND, S_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cmd_q, addr_q, wdata_q, csum_q;
  logic [7:0]  status_q, resp_data_q;
  logic [1:0]  idx_q;
  logic        is_read, is_write;
  logic [7:0]  exp_csum, addr_hi, status_c, resp_byte;
  logic        timeout_hit;

  assign is_read  = (cmd_q == CMD_READ);
  assign is_write = (cmd_q == CMD_WRITE);
  assign exp_csum = cmd_q ^ addr_q ^ (is_write ? wdata_q : 8'h00);
  assign addr_hi  = addr_q >> ADDR_W;

  // Checksum errors outrank command errors, which outrank address errors.
  always_comb begin
    status_c = 8'h00;
    if (csum_q != exp_csum)
      status_c = 8'h01;
    else if (!is_read && !is_write)
      status_c = 8'h02;
    else if (addr_hi != 8'h00)
      status_c = 8'h03;
  end

  always_comb begin
    resp_byte = SYNC_RESP;
    case (idx_q)
      2'd0:    resp_byte = SYNC_RESP;
      2'd1:    resp_byte = status_q;
      2'd2:    resp_byte = resp_data_q;
      default: resp_byte = SYNC_RESP ^ status_q ^ resp_data_q;
    endcase
  end

  assign bus_addr  = addr_q[ADDR_W-1:0];
  assign bus_wdata = wdata_q;
  assign tx_data   = (state == S_SEND || state == S_WAIT) ? resp_byte : 8'h00;

`ifdef UART_RESP_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q;
  logic          collecting;

  assign collecting  = (state == S_CMD) || (state == S_ADDR) ||
                       (state == S_DATA) || (state == S_CSUM);
  assign timeout_hit = collecting && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst || !collecting || rx_ready)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_en     = 1'b0;
    bus_we    = 1'b0;
    case (state)
      S_IDLE: if (rx_ready && rx_data == SYNC_REQ) state_nxt = S_CMD;
      S_CMD: begin
        if (rx_ready)         state_nxt = S_ADDR;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_ADDR: begin
        if (rx_ready)         state_nxt = is_write ? S_DATA : S_CSUM;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (rx_ready)         state_nxt = S_CSUM;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_CSUM: begin
        if (rx_ready)         state_nxt = S_EXEC;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_EXEC: begin
        bus_we    = is_write && (status_c == 8'h00);
        state_nxt = S_SEND;
      end
      S_SEND: begin
        tx_en     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (tx_done) state_nxt = (idx_q == 2'd3) ? S_IDLE : S_SEND;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame fields are captured in the state that owns them; the response is frozen in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      csum_q      <= 8'h00;
      status_q    <= 8'h00;
      resp_data_q <= 8'h00;
      idx_q       <= 2'd0;
    end else begin
      case (state)
        S_CMD:  if (rx_ready) cmd_q   <= rx_data;
        S_ADDR: if (rx_ready) addr_q  <= rx_data;
        S_DATA: if (rx_ready) wdata_q <= rx_data;
        S_CSUM: if (rx_ready) csum_q  <= rx_data;
        S_EXEC: begin
          status_q    <= status_c;
          resp_data_q <= (status_c != 8'h00) ? 8'h00 : (is_read ? bus_rdata : wdata_q);
          idx_q       <= 2'd0;
        end
        S_WAIT: if (tx_done) idx_q <= idx_q + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed testbench for uart_reg_responder; covers UART_RESP_TIMEOUT_EN in both builds.
module tb_uart_reg_responder;

  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;

  int checks = 0;
  int passed = 0;
  int we_total = 0;
  logic [ADDR_W-1:0] we_addr = '0;
  logic [7:0]        we_data = 8'h00;

  always #5 clk = ~clk;

  uart_reg_responder #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // Register bank model: address 5 reads 0xC3, others read 0xA<addr>.
  assign bus_rdata = (bus_addr == 4'd5) ? 8'hC3 : {4'hA, bus_addr};

  always @(negedge clk) begin
    if (bus_we) begin
      we_total <= we_total + 1;
      we_addr  <= bus_addr;
      we_data  <= bus_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] f[5], input int len);
    for (int i = 0; i < len; i++) send_byte(f[i]);
  endtask

  task automatic collect(input int nbytes, input bit last_done, input bit inject,
                         input logic [7:0] inj[4], output logic [7:0] r[4],
                         output int got, output bit hold_ok);
    int w;
    got     = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < 4; i++) r[i] = 8'hxx;
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!tx_en && w < 30) begin
        @(posedge clk); #1;
        w++;
      end
      if (!tx_en) return;
      r[i] = tx_data;
      got++;
      @(posedge clk); #1;
      if (tx_en) hold_ok = 1'b0;
      if (inject) send_byte(inj[i]);
      else begin @(posedge clk); #1; end
      if (tx_data !== r[i]) hold_ok = 1'b0;
      if (i < nbytes - 1 || last_done) begin
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end
    end
  endtask

  task automatic expect_silence(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (tx_en) seen = 1'b1;
    end
    checks++;
    if (seen) $display("[TB] FAIL %s: tx_en got 1 required 0", nm);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (tx_en !== 1'b0) $display("[TB] FAIL reset_tx_en: got %b required 0", tx_en); else passed++;
    if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h required 00", tx_data); else passed++;
    if (bus_we !== 1'b0) $display("[TB] FAIL reset_bus_we: got %b required 0", bus_we); else passed++;
    if (bus_addr !== 4'h0) $display("[TB] FAIL reset_bus_addr: got %h required 0", bus_addr); else passed++;
    if (bus_wdata !== 8'h00) $display("[TB] FAIL reset_bus_wdata: got %h required 00", bus_wdata); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    send_byte(8'hA5);
    send_byte(8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_byte(8'h03); send_byte(8'h7E); send_byte(8'h7F);
    expect_silence("reset_partial_frame");
  endtask

  task automatic test_write();
    logic [7:0] f[5], r[4], e[4], inj[4];
    int got, we0; bit hold_ok, lat;
    f = '{8'hA5, 8'h02, 8'h03, 8'h7E, 8'h7F};
    e = '{8'h5A, 8'h00, 8'h7E, 8'h24};
    inj = '{8'h00, 8'h00, 8'h00, 8'h00};
    we0 = we_total;
    send_frame(f, 5);
    @(posedge clk); #1;
    lat = tx_en;
    collect(4, 1'b1, 1'b0, inj, r, got, hold_ok);
    checks += 6;
    if (lat !== 1'b1) $display("[TB] FAIL write_latency: tx_en got %b required 1", lat); else passed++;
    if (got != 4) $display("[TB] FAIL write_count: got %0d required 4", got); else passed++;
    if (!hold_ok) $display("[TB] FAIL write_tx_hold: got 0 required 1"); else passed++;
    if (we_total - we0 != 1) $display("[TB] FAIL write_we_count: got %0d required 1", we_total - we0); else passed++;
    if (we_addr !== 4'd3) $display("[TB] FAIL write_addr: got %h required 3", we_addr); else passed++;
    if (we_data !== 8'h7E) $display("[TB] FAIL write_wdata: got %h required 7e", we_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r[i] !== e[i]) $display("[TB] FAIL write_tx%0d: got %h required %h", i, r[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_read();
    logic [7:0] f[5], r[4], e[4], inj[4];
    int got, we0; bit hold_ok, lat;
    f = '{8'hA5, 8'h01, 8'h05, 8'h04, 8'h00};
    e = '{8'h5A, 8'h00, 8'hC3, 8'h99};
    inj = '{8'h00, 8'h00, 8'h00, 8'h00};
    we0 = we_total;
    send_frame(f, 4);
    @(posedge clk); #1;
    lat = tx_en;
    collect(4, 1'b1, 1'b0, inj, r, got, hold_ok);
    checks += 4;
    if (lat !== 1'b1) $display("[TB] FAIL read_latency: tx_en got %b required 1", lat); else passed++;
    if (got != 4) $display("[TB] FAIL read_count: got %0d required 4", got); else passed++;
    if (!hold_ok) $display("[TB] FAIL read_tx_hold: got 0 required 1"); else passed++;
    if (we_total != we0) $display("[TB] FAIL read_no_we: got %0d required 0", we_total - we0); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r[i] !== e[i]) $display("[TB] FAIL read_tx%0d: got %h required %h", i, r[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic [7:0] f[3][5], e[3][4], fr[5], r[4], inj[4];
    int len[3]; string nm[3];
    int got, we0; bit hold_ok;
    f[0] = '{8'hA5, 8'h02, 8'h03, 8'h7E, 8'h00}; e[0] = '{8'h5A, 8'h01, 8'h00, 8'h5B};
    f[1] = '{8'hA5, 8'h01, 8'h10, 8'h11, 8'h00}; e[1] = '{8'h5A, 8'h03, 8'h00, 8'h59};
    f[2] = '{8'hA5, 8'h07, 8'h00, 8'h07, 8'h00}; e[2] = '{8'h5A, 8'h02, 8'h00, 8'h58};
    len = '{5, 4, 4};
    nm  = '{"bad_csum", "bad_addr", "bad_cmd"};
    inj = '{8'h00, 8'h00, 8'h00, 8'h00};
    for (int t = 0; t < 3; t++) begin
      fr = f[t];
      we0 = we_total;
      send_frame(fr, len[t]);
      collect(4, 1'b1, 1'b0, inj, r, got, hold_ok);
      checks += 2;
      if (got != 4) $display("[TB] FAIL %s_count: got %0d required 4", nm[t], got); else passed++;
      if (we_total != we0) $display("[TB] FAIL %s_no_we: got %0d required 0", nm[t], we_total - we0); else passed++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (r[i] !== e[t][i]) $display("[TB] FAIL %s_tx%0d: got %h required %h", nm[t], i, r[i], e[t][i]);
        else passed++;
      end
    end
  endtask

  task automatic test_garbage();
    logic [7:0] f[5], r[4], e[4], inj[4];
    int got; bit hold_ok;
    f = '{8'hA5, 8'h01, 8'h05, 8'h04, 8'h00};
    e = '{8'h5A, 8'h00, 8'hC3, 8'h99};
    inj = '{8'h00, 8'h00, 8'h00, 8'h00};
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_frame(f, 4);
    collect(4, 1'b1, 1'b0, inj, r, got, hold_ok);
    checks++;
    if (got != 4) $display("[TB] FAIL garbage_count: got %0d required 4", got); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r[i] !== e[i]) $display("[TB] FAIL garbage_tx%0d: got %h required %h", i, r[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_rx_during_response();
    logic [7:0] f[5], r[4], e[4], inj[4];
    int got; bit hold_ok;
    f = '{8'hA5, 8'h02, 8'h03, 8'h7E, 8'h7F};
    e = '{8'h5A, 8'h00, 8'h7E, 8'h24};
    inj = '{8'hA5, 8'h01, 8'h05, 8'h04};
    send_frame(f, 5);
    collect(4, 1'b1, 1'b1, inj, r, got, hold_ok);
    checks += 2;
    if (got != 4) $display("[TB] FAIL rxdrop_count: got %0d required 4", got); else passed++;
    if (!hold_ok) $display("[TB] FAIL rxdrop_tx_hold: got 0 required 1"); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r[i] !== e[i]) $display("[TB] FAIL rxdrop_tx%0d: got %h required %h", i, r[i], e[i]);
      else passed++;
    end
    expect_silence("rxdrop_no_extra_response");
  endtask

  task automatic test_reset_mid_response();
    logic [7:0] f[5], r[4], e[4], inj[4];
    int got; bit hold_ok;
    f = '{8'hA5, 8'h02, 8'h03, 8'h7E, 8'h7F};
    inj = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(f, 5);
    collect(2, 1'b0, 1'b0, inj, r, got, hold_ok);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks += 2;
    if (got != 2) $display("[TB] FAIL midrst_count: got %0d required 2", got); else passed++;
    if (tx_data !== 8'h00) $display("[TB] FAIL midrst_tx_data: got %h required 00", tx_data); else passed++;
    rst = 1'b0;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    expect_silence("midrst_no_tx");
    f = '{8'hA5, 8'h01, 8'h05, 8'h04, 8'h00};
    e = '{8'h5A, 8'h00, 8'hC3, 8'h99};
    send_frame(f, 4);
    collect(4, 1'b1, 1'b0, inj, r, got, hold_ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r[i] !== e[i]) $display("[TB] FAIL midrst_next_tx%0d: got %h required %h", i, r[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[5], f2[5], r1[4], r2[4], e1[4], e2[4], inj[4];
    int got1, got2, we0; bit hold_ok;
    f1 = '{8'hA5, 8'h02, 8'h07, 8'h11, 8'h14};
    e1 = '{8'h5A, 8'h00, 8'h11, 8'h4B};
    f2 = '{8'hA5, 8'h01, 8'h07, 8'h06, 8'h00};
    e2 = '{8'h5A, 8'h00, 8'hA7, 8'hFD};
    inj = '{8'h00, 8'h00, 8'h00, 8'h00};
    we0 = we_total;
    send_frame(f1, 5);
    collect(4, 1'b1, 1'b0, inj, r1, got1, hold_ok);
    send_frame(f2, 4);
    collect(4, 1'b1, 1'b0, inj, r2, got2, hold_ok);
    checks += 3;
    if (got1 != 4 || got2 != 4) $display("[TB] FAIL b2b_count: got %0d/%0d required 4/4", got1, got2); else passed++;
    if (we_total - we0 != 1) $display("[TB] FAIL b2b_we_count: got %0d required 1", we_total - we0); else passed++;
    if (we_data !== 8'h11) $display("[TB] FAIL b2b_wdata: got %h required 11", we_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (r1[i] !== e1[i]) $display("[TB] FAIL b2b_first_tx%0d: got %h required %h", i, r1[i], e1[i]); else passed++;
      if (r2[i] !== e2[i]) $display("[TB] FAIL b2b_second_tx%0d: got %h required %h", i, r2[i], e2[i]); else passed++;
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
`ifdef UART_RESP_TIMEOUT_EN
    repeat (100) @(posedge clk);
    #1;
    send_byte(8'h05);
    send_byte(8'h04);
    expect_silence("timeout_no_response");
`else
    begin
      logic [7:0] r[4], e[4], inj[4];
      int got; bit hold_ok;
      e = '{8'h5A, 8'h00, 8'hC3, 8'h99};
      inj = '{8'h00, 8'h00, 8'h00, 8'h00};
      repeat (150) @(posedge clk);
      #1;
      send_byte(8'h05);
      send_byte(8'h04);
      collect(4, 1'b1, 1'b0, inj, r, got, hold_ok);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (r[i] !== e[i]) $display("[TB] FAIL no_timeout_tx%0d: got %h required %h", i, r[i], e[i]);
        else passed++;
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_garbage();
    test_rx_during_response();
    test_reset_mid_response();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
